// File: rtl/spk_in_dispatch_pkg.sv
// Shared node package: flit-type encoding and decode helper used by the
// input dispatcher and the config controller.
package spk_in_dispatch_pkg;

   localparam int unsigned FT_SPIKE   = 0;
   localparam int unsigned FT_ILLEGAL = 7;

   typedef enum logic [1:0] {
      FC_SPIKE   = 2'd0,
      FC_CONFIG  = 2'd1,
      FC_ILLEGAL = 2'd2
   } flit_class_e;

   function automatic flit_class_e decode_ftype(input logic [31:0] ft);
      if (ft == FT_SPIKE)   return FC_SPIKE;
      if (ft == FT_ILLEGAL) return FC_ILLEGAL;
      return FC_CONFIG;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head is read straight from the
// storage array so dout never depends combinationally on din.
module sync_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DW-1:0]            din,
   output logic [DW-1:0]            dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;

   // Wrap explicitly so non-power-of-two depths stay in range.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
   endfunction

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];
   assign cnt     = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
         else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/spk_in_dispatch.sv
// Router-side input dispatcher: spike flits to a 1-entry axon buffer, config
// flits to a credit-gated FIFO, illegal flits dropped with a sticky flag.
module spk_in_dispatch
   import spk_in_dispatch_pkg::*;
#(
   parameter int FW  = 59,
   parameter int FTW = 3,
   parameter int CRD = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   router_vld,
   input  logic [FW-1:0]          router_flit,
   output logic                   router_rdy,
   output logic                   spk_in_axon_we,
   output logic [FW-1:0]          spk_in_axon_wdata,
   input  logic                   axon_busy,
   output logic                   spk_in_config_we,
   output logic [FW-1:0]          spk_in_config_wdata,
   input  logic                   config_spk_in_credit,
   output logic [$clog2(CRD):0]   cfg_fifo_cnt,
   output logic                   err_bad_type,
   output logic                   err_credit_ovf
);

   localparam int CW = $clog2(CRD) + 1;

   flit_class_e   fcls;
   logic          spk_full, spk_rdy, spk_push;
   logic          cfg_rdy, cfg_push, cfg_pop, fifo_full, fifo_empty;
   logic          bad_flit;
   logic [CW-1:0] credit;

   assign fcls = decode_ftype(32'(router_flit[FW-1 -: FTW]));

   // Spike path: drain and refill may happen in the same cycle.
   assign spk_in_axon_we = spk_full && !axon_busy;
   assign spk_rdy        = !spk_full || !axon_busy;

   // Config path: ready/pop use only registered state, never router_flit data.
   assign cfg_pop          = !fifo_empty && (credit != '0);
   assign spk_in_config_we = cfg_pop;
   assign cfg_rdy          = !fifo_full || cfg_pop;

   always_comb begin
      router_rdy = 1'b1;
      case (fcls)
         FC_SPIKE:   router_rdy = spk_rdy;
         FC_CONFIG:  router_rdy = cfg_rdy;
         default:    router_rdy = 1'b1;
      endcase
   end

   assign spk_push = router_vld && (fcls == FC_SPIKE)   && spk_rdy;
   assign cfg_push = router_vld && (fcls == FC_CONFIG)  && cfg_rdy;
   assign bad_flit = router_vld && (fcls == FC_ILLEGAL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spk_full          <= 1'b0;
         spk_in_axon_wdata <= '0;
         err_bad_type      <= 1'b0;
      end else begin
         if (spk_push) begin
            spk_full          <= 1'b1;
            spk_in_axon_wdata <= router_flit;
         end else if (spk_in_axon_we) begin
            spk_full <= 1'b0;
         end
         if (bad_flit) err_bad_type <= 1'b1;
      end
   end

   // A credit arriving with a pop cancels out; a surplus credit is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit         <= CW'(CRD);
         err_credit_ovf <= 1'b0;
      end else if (cfg_pop && !config_spk_in_credit) begin
         credit <= credit - CW'(1);
      end else if (config_spk_in_credit && !cfg_pop) begin
         if (credit == CW'(CRD)) err_credit_ovf <= 1'b1;
         else                    credit         <= credit + CW'(1);
      end
   end

   sync_fifo #(.DW(FW), .DEPTH(CRD)) u_cfg_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cfg_push),
      .pop   (cfg_pop),
      .din   (router_flit),
      .dout  (spk_in_config_wdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .cnt   (cfg_fifo_cnt)
   );

endmodule

// File: doc/spk_in_dispatch.md
SPK_IN_DISPATCH -- requirements
Module: spk_in_dispatch

Interface
REQ-001 SHALL have parameter FW, default 59, meaning flit width.
REQ-002 SHALL have parameter FTW, default 3, meaning flit-type field width, field located at flit[FW-1:FW-FTW].
REQ-003 SHALL have parameter CRD, default 4, meaning config credits granted after reset; this is also the config FIFO depth.
REQ-004 SHALL have these ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- router_vld  in  1  incoming flit valid.
- router_flit  in  FW  incoming flit.
- router_rdy  out  1  flit accepted when router_vld && router_rdy.
- spk_in_axon_we  out  1  spike flit strobe to axon.
- spk_in_axon_wdata  out  FW  spike flit.
- axon_busy  in  1  axon cannot take a flit this cycle.
- spk_in_config_we  out  1  config flit strobe to the config controller.
- spk_in_config_wdata  out  FW  config flit.
- config_spk_in_credit  in  1  one-cycle pulse returning one credit.
- cfg_fifo_cnt  out  $clog2(CRD)+1  config FIFO occupancy.
- err_bad_type  out  1  sticky: a type-7 flit was dropped.
- err_credit_ovf  out  1  sticky: a credit pulse arrived while the counter was at CRD.

Function
REQ-005 SHALL decode the flit type as follows: 0 = spike; 1..6 = config; 7 = illegal.
REQ-006 SHALL hold spike flits in a 1-entry register (spk_full). router_rdy for a type-0 flit SHALL be !spk_full || !axon_busy.
REQ-007 SHALL assert spk_in_axon_we = spk_full && !axon_busy; the entry drains in that same cycle, and a new spike flit MAY load in that same cycle.
REQ-008 SHALL give spike latency as: accepted at cycle t, spk_in_axon_we no earlier than t+1.
REQ-009 SHALL push config flits into a CRD-deep FIFO. router_rdy for a type 1..6 flit SHALL be !fifo_full || pop_this_cycle.
REQ-010 SHALL keep an internal credit counter, reset to CRD: decrement on spk_in_config_we, increment on config_spk_in_credit, unchanged when both occur together.
REQ-011 SHALL pop the FIFO with spk_in_config_we = !fifo_empty && (credit > 0). spk_in_config_wdata SHALL be the FIFO head, registered, stable while we is high, and not a combinational path from router_flit.
REQ-012 SHALL give config latency as: accepted at cycle t into an empty FIFO with credit > 0, spk_in_config_we at t+1.
REQ-013 SHALL keep router_rdy = 1 for a type-7 flit, discard the flit, and set err_bad_type.
REQ-014 SHALL ignore a credit pulse when the counter is at CRD and no pop occurs that cycle; the counter stays at CRD and err_credit_ovf is set.
REQ-015 SHALL allow FIFO push and pop in the same cycle, leaving the count unchanged, including when the FIFO is full; pointers SHALL wrap modulo CRD.
REQ-016 SHALL keep the spike and config paths independent: a stall on one SHALL NOT block acceptance of flits for the other.
REQ-017 SHALL make router_rdy depend only on the decoded type of router_flit and on registered state.

Reset
REQ-018 SHALL, on rst_n low, asynchronously clear: router_rdy inputs-independent state, spk_full, FIFO pointers/count, spk_in_axon_we, spk_in_config_we, both wdata registers (0), and both error flags. The credit counter SHALL load CRD.
REQ-019 SHALL discard in-flight flits on reset mid-operation; no strobe SHALL be issued in the first cycle after release.

Structure
REQ-020 SHALL define the flit-type constants (FT_SPIKE=0, FT_ILLEGAL=7) in the shared node package used by config_ctrl.
REQ-021 SHALL implement the config FIFO as a sub-module named sync_fifo (params DW, DEPTH; push/pop/full/empty/cnt). The spike register and credit counter SHALL stay in spk_in_dispatch.

Verification
REQ-022 After reset, push 6 config flits back-to-back with no credits returned -> exactly 4 spk_in_config_we pulses at cycles 1..4; cfg_fifo_cnt=2; router_rdy stays 1 (FIFO not full).
REQ-023 Continuing REQ-022: push 3 more config flits -> the 5th pushed flit (FIFO full) sees router_rdy=0; one credit pulse -> one we pulse and cfg_fifo_cnt drops by one.
REQ-024 Spike flit 0x0..01 with axon_busy=1 for 3 cycles -> spk_in_axon_we held off, then asserted in the first cycle axon_busy=0, with data 0x0..01; a second spike flit is refused while the entry is full and busy.
REQ-025 Interleave a type-7 flit between two spike flits -> the type-7 flit is accepted and dropped, err_bad_type=1, and both spike flits are delivered in order.
REQ-026 Credit pulse while counter=4 -> err_credit_ovf=1, counter stays 4; simultaneous pop and credit -> counter unchanged.
REQ-027 Assert rst_n low with 2 flits queued and a spike pending -> all strobes 0, cfg_fifo_cnt=0, credit=4 after release.
